// File: rtl/xfer_block_copy_seq_pkg.sv
// Shared definitions for the block-copy address sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package xfer_block_copy_seq_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int CNT_W_DEF  = 8;
   localparam int DATA_W     = 8;

   // Memory strobes, transfer-register load and the start/abort controls are all active low.
   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      WBACK = 2'd3
   } state_t;

endpackage

// File: rtl/xfer_block_copy_seq_if.sv
// Byte-wide memory bus with a single ready line used for wait states.
// Latency: n/a (signal bundle only).
// Backpressure: slave holds mem_ready low to stretch the current read or write cycle.
interface xfer_block_copy_seq_if #(
   parameter int ADDR_W = xfer_block_copy_seq_pkg::ADDR_W_DEF
);

   logic [ADDR_W-1:0]                         AddrOut;
   logic [xfer_block_copy_seq_pkg::DATA_W-1:0] DataOut;
   logic [xfer_block_copy_seq_pkg::DATA_W-1:0] DataIn;
   logic                                      mem_read_n;
   logic                                      mem_write_n;
   logic                                      mem_ready;

   modport master (
      output AddrOut,
      output DataOut,
      output mem_read_n,
      output mem_write_n,
      input  DataIn,
      input  mem_ready
   );

   modport slave (
      input  AddrOut,
      input  DataOut,
      input  mem_read_n,
      input  mem_write_n,
      output DataIn,
      output mem_ready
   );

endinterface

// File: rtl/xfer_block_copy_seq_ptr_step.sv
// Pointer stepper: ptr+1 when dir=0, ptr-1 when dir=1, wrapping modulo 2^ADDR_W.
// Latency: combinational.
// Backpressure: none.
module xfer_block_copy_seq_ptr_step #(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] ptr,
   input  logic              dir,
   output logic [ADDR_W-1:0] ptr_nxt
);

   // Plain modular add/subtract; wrap-around carries no flag.
   assign ptr_nxt = dir ? (ptr - ADDR_W'(1)) : (ptr + ADDR_W'(1));

endmodule

// File: rtl/xfer_block_copy_seq.sv
// Block-copy sequencer: reads src, writes dst, byte by byte, then writes the final src back to the transfer register.
// Latency: first read strobe one cycle after the start edge; N bytes at zero wait take 2N cycles plus one writeback cycle.
// Backpressure: mem_ready low stretches the current phase indefinitely; abort only takes effect once the current byte has been written.
module xfer_block_copy_seq #(
   parameter int ADDR_W = xfer_block_copy_seq_pkg::ADDR_W_DEF,
   parameter int CNT_W  = xfer_block_copy_seq_pkg::CNT_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADDR_W-1:0]            XferRegIn,
   input  logic [ADDR_W-1:0]            AddrBusIn,
   input  logic [CNT_W-1:0]             MainBusIn,
   input  logic                         seq_start,
   input  logic                         seq_dir,
   input  logic                         seq_abort,
   xfer_block_copy_seq_if.master        mem,
   output logic [ADDR_W-1:0]            XferBusOut,
   output logic                         xfer_load_n,
   output logic                         busy,
   output logic                         done
);

   import xfer_block_copy_seq_pkg::*;

   state_t            state;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [ADDR_W-1:0] src_nxt;
   logic [ADDR_W-1:0] dst_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              dir;
   logic              abort_pend;
   logic              start_req;
   logic              abort_now;
   logic              last_byte;

   xfer_block_copy_seq_ptr_step #(.ADDR_W(ADDR_W)) u_src_step (
      .ptr     (src),
      .dir     (dir),
      .ptr_nxt (src_nxt)
   );

   xfer_block_copy_seq_ptr_step #(.ADDR_W(ADDR_W)) u_dst_step (
      .ptr     (dst),
      .dir     (dir),
      .ptr_nxt (dst_nxt)
   );

   // An abort presented together with start suppresses the start.
   assign start_req = (seq_start == STROBE_ON) && (seq_abort != STROBE_ON);
   assign abort_now = (seq_abort == STROBE_ON);
   // A write that completes with an abort seen now or earlier ends the copy, as does the final byte.
   assign last_byte = (cnt == CNT_W'(1)) || abort_pend || abort_now;

   // Sequencer FSM; every output is a register updated alongside the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         src             <= '0;
         dst             <= '0;
         cnt             <= '0;
         dir             <= 1'b0;
         abort_pend      <= 1'b0;
         mem.AddrOut     <= '0;
         mem.DataOut     <= '0;
         mem.mem_read_n  <= STROBE_OFF;
         mem.mem_write_n <= STROBE_OFF;
         XferBusOut      <= '0;
         xfer_load_n     <= STROBE_OFF;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_req) begin
                  src        <= XferRegIn;
                  dst        <= AddrBusIn;
                  cnt        <= MainBusIn;
                  dir        <= seq_dir;
                  abort_pend <= 1'b0;
                  busy       <= 1'b1;
                  if (MainBusIn == '0) begin
                     // Nothing to copy: hand the source pointer straight back.
                     state       <= WBACK;
                     XferBusOut  <= XferRegIn;
                     xfer_load_n <= STROBE_ON;
                  end else begin
                     state          <= READ;
                     mem.AddrOut    <= XferRegIn;
                     mem.mem_read_n <= STROBE_ON;
                  end
               end
            end
            READ: begin
               if (abort_now) abort_pend <= 1'b1;
               if (mem.mem_ready) begin
                  // DataOut doubles as the byte buffer between read and write.
                  mem.DataOut     <= mem.DataIn;
                  mem.AddrOut     <= dst;
                  mem.mem_read_n  <= STROBE_OFF;
                  mem.mem_write_n <= STROBE_ON;
                  state           <= WRITE;
               end
            end
            WRITE: begin
               if (abort_now) abort_pend <= 1'b1;
               if (mem.mem_ready) begin
                  src             <= src_nxt;
                  dst             <= dst_nxt;
                  cnt             <= cnt - CNT_W'(1);
                  mem.mem_write_n <= STROBE_OFF;
                  if (last_byte) begin
                     state       <= WBACK;
                     XferBusOut  <= src_nxt;
                     xfer_load_n <= STROBE_ON;
                  end else begin
                     state          <= READ;
                     mem.AddrOut    <= src_nxt;
                     mem.mem_read_n <= STROBE_ON;
                  end
               end
            end
            WBACK: begin
               xfer_load_n <= STROBE_OFF;
               abort_pend  <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
